// File: rtl/wave_plotter_if.sv
// Sample stream in, framebuffer write port out, plus frame control/status.
// slave is the plotter's view; master is the driver/monitor side.
interface wave_plotter_if #(
    parameter int COL_BITS = 8,
    parameter int ROW_BITS = 7,
    parameter int SAMPLE_W = 8
);
    logic                         start;
    logic [SAMPLE_W-1:0]          sample;
    logic                         sample_valid;
    logic                         sample_ready;
    logic [COL_BITS+ROW_BITS-1:0] ada;
    logic                         din;
    logic                         cea;
    logic                         busy;
    logic                         frame_done;

    modport master (
        output start, sample, sample_valid,
        input  sample_ready, ada, din, cea, busy, frame_done
    );

    modport slave (
        input  start, sample, sample_valid,
        output sample_ready, ada, din, cea, busy, frame_done
    );
endinterface

// File: rtl/wave_plotter.sv
// Clears a 2^COL_BITS x 2^ROW_BITS 1-bit framebuffer, then plots one sample per column as a connected trace.
// Latency: ada/din/cea registered, one write per cycle; optional graticule on clear via WAVE_PLOTTER_GRID_EN.
// Backpressure: sample_ready is high only while waiting for the next column's sample.
module wave_plotter #(
    parameter int COL_BITS = 8,
    parameter int ROW_BITS = 7,
    parameter int SAMPLE_W = 8
) (
    input  logic           clka,
    input  logic           reseta,
    wave_plotter_if.slave  bus
);
    localparam int AW = COL_BITS + ROW_BITS;
    localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SAMPLE,
        DRAW,
        DONE
    } state_t;

    state_t              state;
    logic [AW-1:0]       clr_addr;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] prev_y;
    logic [ROW_BITS-1:0] cur_y;
    logic [ROW_BITS-1:0] target;
    logic                first;
    logic [AW-1:0]       ada_q;
    logic                din_q;
    logic                cea_q;

    logic [ROW_BITS-1:0] sample_y;
    logic                clr_din;

    // Full scale sits at the top row, zero at the bottom.
    assign sample_y = ROW_LAST - bus.sample[SAMPLE_W-1 -: ROW_BITS];

`ifdef WAVE_PLOTTER_GRID_EN
    assign clr_din = ((clr_addr[4:0] == 5'd0) && !clr_addr[COL_BITS]) ||
                     ((clr_addr[COL_BITS+3:COL_BITS] == 4'd0) && !clr_addr[0]);
`else
    assign clr_din = 1'b0;
`endif

    always_ff @(posedge clka or posedge reseta) begin
        if (reseta) begin
            state    <= IDLE;
            clr_addr <= '0;
            col      <= '0;
            prev_y   <= '0;
            cur_y    <= '0;
            target   <= '0;
            first    <= 1'b0;
            ada_q    <= '0;
            din_q    <= 1'b0;
            cea_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cea_q <= 1'b0;
                    if (bus.start) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    cea_q    <= 1'b1;
                    din_q    <= clr_din;
                    ada_q    <= clr_addr;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state <= SAMPLE;
                        col   <= '0;
                        first <= 1'b1;
                    end
                end
                SAMPLE: begin
                    cea_q <= 1'b0;
                    if (bus.sample_valid) begin
                        target <= sample_y;
                        cur_y  <= first ? sample_y : prev_y;
                        state  <= DRAW;
                    end
                end
                DRAW: begin
                    // The run includes both endpoints, so prev_y is redrawn on purpose.
                    cea_q <= 1'b1;
                    din_q <= 1'b1;
                    ada_q <= {cur_y, col};
                    if (cur_y == target) begin
                        prev_y <= target;
                        first  <= 1'b0;
                        if (col == '1) begin
                            state <= DONE;
                        end else begin
                            col   <= col + 1'b1;
                            state <= SAMPLE;
                        end
                    end else if (cur_y < target) begin
                        cur_y <= cur_y + 1'b1;
                    end else begin
                        cur_y <= cur_y - 1'b1;
                    end
                end
                DONE: begin
                    cea_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    cea_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ada          = ada_q;
    assign bus.din          = din_q;
    assign bus.cea          = cea_q;
    assign bus.sample_ready = (state == SAMPLE);
    assign bus.busy         = (state != IDLE);
    assign bus.frame_done   = (state == DONE);
endmodule
